// File: rtl/cache_req_sequencer_pkg.sv
// Shared types for the cache request sequencer.
//   cmd_e        trace command codes understood by the cache
//   req_t        one buffered request {n, address}
//   seq_state_e  issue FSM states
//   is_legal_cmd returns 1 for codes the cache accepts
package cache_pkg;

  localparam int REQ_ADDR_W = 32;

  typedef enum logic [3:0] {
    CMD_RD_DATA = 4'd0,
    CMD_WR_DATA = 4'd1,
    CMD_RD_INST = 4'd2,
    CMD_INVAL   = 4'd3,
    CMD_SNOOP   = 4'd4,
    CMD_CLEAR   = 4'd8,
    CMD_PRINT   = 4'd9
  } cmd_e;

  typedef struct packed {
    cmd_e                  n;
    logic [REQ_ADDR_W-1:0] address;
  } req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} seq_state_e;

  function automatic logic is_legal_cmd(logic [3:0] c);
    case (c)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cache_req_sequencer_if.sv
// Bus bundle of the sequencer: push port from the trace source and the
// strobe port toward the cache.
//   in_valid/in_ready/in_n/in_address  push handshake (source -> sequencer)
//   valid/n/address                    request strobe (sequencer -> cache)
// slave = sequencer view, master = trace source / bench view.
interface cache_req_sequencer_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_n;
  logic [ADDR_W-1:0] in_address;
  logic              valid;
  logic [3:0]        n;
  logic [ADDR_W-1:0] address;

  modport slave  (input  in_valid, in_n, in_address,
                  output in_ready, valid, n, address);
  modport master (output in_valid, in_n, in_address,
                  input  in_ready, valid, n, address);
endinterface

// File: rtl/cache_req_sequencer_fifo.sv
// cache_req_fifo: DEPTH-entry request FIFO.
//   clk, rstb   clock / async active-low reset
//   push_i      write wdata_i (caller guarantees not full, no flush)
//   pop_i       advance head (ignored when empty)
//   flush_i     clear contents at next edge, overrides push/pop
//   rdata_o     head entry
//   full_o, empty_o, level_o  occupancy status
module cache_req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  req_t                   wdata_i,
  output req_t                   rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  req_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty; the difference is the level.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cache_req_sequencer.sv
// cache_req_sequencer: buffers trace requests and replays them to the cache
// as one-cycle valid strobes spaced GAP+1 cycles apart.
//   clk, rstb     clock / async active-low reset
//   flush         synchronous FIFO clear (blocks pushes while high)
//   bus           push port + cache strobe port (cache_req_sequencer_if.slave)
//   busy          FSM not idle or FIFO holding entries
//   level         FIFO occupancy
//   issued_cnt    strobes sent, drop_cnt illegal codes discarded
//   rd/wr/if_cnt  per-command issue counts, only when SEQ_CMD_STATS_EN is
//                 defined; otherwise constant 0
// All counters saturate at all-ones.
module cache_req_sequencer
  import cache_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int GAP    = 100,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   flush,
  cache_req_sequencer_if.slave   bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic [CNT_W-1:0]       if_cnt
);
  localparam int GW = $clog2(GAP + 1);

  seq_state_e        state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              valid_q;
  logic [3:0]        n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  issued_q, drop_q;
  logic              full, empty, push_fire, legal, issue;
  req_t              head, wreq;

  // rstb gates ready so the source sees no room while reset is held.
  assign bus.in_ready = rstb & ~full & ~flush;
  assign push_fire    = bus.in_valid & bus.in_ready;
  assign legal        = is_legal_cmd(bus.in_n);
  assign wreq.n       = cmd_e'(bus.in_n);
  assign wreq.address = REQ_ADDR_W'(bus.in_address);

  cache_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (push_fire & legal),
    .pop_i   (issue),
    .flush_i (flush),
    .wdata_i (wreq),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        // A flush landing on the ISSUE edge can leave nothing to send.
        issue = !empty;
        if (!empty) begin
          gap_d   = GW'(GAP);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = empty ? ST_IDLE : ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      n_q      <= '0;
      addr_q   <= '0;
      issued_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= issue;
      if (issue) begin
        n_q    <= head.n;
        addr_q <= ADDR_W'(head.address);
      end
      if (issue && issued_q != '1) issued_q <= issued_q + CNT_W'(1);
      if (push_fire && !legal && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign bus.valid   = valid_q;
  assign bus.n       = n_q;
  assign bus.address = addr_q;
  assign busy        = (state_q != ST_IDLE) | ~empty;
  assign issued_cnt  = issued_q;
  assign drop_cnt    = drop_q;

`ifdef SEQ_CMD_STATS_EN
  logic [CNT_W-1:0] rd_q, wr_q, if_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_q <= '0;
      wr_q <= '0;
      if_q <= '0;
    end else if (issue) begin
      case (head.n)
        CMD_RD_DATA: if (rd_q != '1) rd_q <= rd_q + CNT_W'(1);
        CMD_WR_DATA: if (wr_q != '1) wr_q <= wr_q + CNT_W'(1);
        CMD_RD_INST: if (if_q != '1) if_q <= if_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign rd_cnt = rd_q;
  assign wr_cnt = wr_q;
  assign if_cnt = if_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
  assign if_cnt = '0;
`endif

endmodule
